// File: rtl/ps2_pkg.sv
// ps2_pkg: shared receiver state, PS/2 prefix codes and frame length
package ps2_pkg;
    typedef enum logic {RX_IDLE = 1'b0, RX_RECV = 1'b1} rx_state_t;
    localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
    localparam logic [7:0] PS2_EXT_CODE = 8'hE0;
    localparam int PS2_FRAME_BITS = 11;
endpackage

// File: rtl/ps2_clk_filter.sv
// ps2_clk_filter: synchronizes ps2_clk/ps2_data, deglitches ps2_clk and strobes each falling edge
module ps2_clk_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic sample,
    output logic data
);
    localparam int CW = $clog2(FILTER_LEN + 1);
    logic [1:0] clk_sync, data_sync;
    logic filt;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync <= 2'b11;
            data_sync <= 2'b11;
            filt <= 1'b1;
            cnt <= '0;
            sample <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            sample <= 1'b0;
            // a new level is accepted only after FILTER_LEN consecutive mismatching cycles
            if (clk_sync[1] == filt) cnt <= '0;
            else if (cnt == CW'(FILTER_LEN - 1)) begin
                filt <= clk_sync[1];
                cnt <= '0;
                sample <= filt;
            end else cnt <= cnt + 1'b1;
        end
    end
    assign data = data_sync[1];
endmodule

// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: PS/2 keyboard frame receiver and scan-code decoder; PS2_PARITY_CHECK_EN enables odd-parity checking
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_code,
    output logic       key_valid,
    output logic       key_released,
    output logic       key_extended,
    output logic       frame_error
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0] STOP_IDX = 4'(PS2_FRAME_BITS - 1);
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES - 1);
    logic sample, data, parity_ok, done, bad, brk, ext;
    rx_state_t state;
    logic [3:0] bit_cnt;
    logic [7:0] shift, rx_byte;
    logic [TW-1:0] tcnt;
    ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .clk(clk),
        .rst(rst),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .sample(sample),
        .data(data)
    );
`ifdef PS2_PARITY_CHECK_EN
    logic par;
    always_ff @(posedge clk) begin
        if (rst) par <= 1'b0;
        else if (state == RX_RECV && sample && bit_cnt == 4'd9) par <= data;
    end
    assign parity_ok = ^{par, shift};
`else
    assign parity_ok = 1'b1;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RX_IDLE;
            bit_cnt <= '0;
            shift <= '0;
            tcnt <= '0;
            done <= 1'b0;
            bad <= 1'b0;
            rx_byte <= '0;
        end else begin
            done <= 1'b0;
            bad <= 1'b0;
            if (state == RX_IDLE) begin
                tcnt <= '0;
                if (sample && !data) begin
                    state <= RX_RECV;
                    bit_cnt <= 4'd1;
                end
            end else if (sample) begin
                tcnt <= '0;
                if (bit_cnt == STOP_IDX) begin
                    state <= RX_IDLE;
                    bit_cnt <= '0;
                    done <= data && parity_ok;
                    bad <= !(data && parity_ok);
                    rx_byte <= shift;
                end else begin
                    if (bit_cnt < 4'd9) shift <= {data, shift[7:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (tcnt == T_MAX) begin
                state <= RX_IDLE;
                bit_cnt <= '0;
                tcnt <= '0;
                bad <= 1'b1;
            end else tcnt <= tcnt + 1'b1;
        end
    end
    // second stage: prefix tracking and key event outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            brk <= 1'b0;
            ext <= 1'b0;
            key_code <= '0;
            key_valid <= 1'b0;
            key_released <= 1'b0;
            key_extended <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            key_released <= 1'b0;
            frame_error <= bad;
            if (bad) begin
                brk <= 1'b0;
                ext <= 1'b0;
            end else if (done) begin
                if (rx_byte == PS2_BREAK_CODE) brk <= 1'b1;
                else if (rx_byte == PS2_EXT_CODE) ext <= 1'b1;
                else begin
                    key_code <= rx_byte;
                    key_extended <= ext;
                    key_released <= brk;
                    key_valid <= !brk;
                    brk <= 1'b0;
                    ext <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb_ps2_keyboard_rx: randomized PS/2 frames checked against a prefix-aware event model
module tb_ps2_keyboard_rx;
    localparam int HB = 20;
    localparam int TO = 200;
    localparam int LAT = 8;
`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
    logic [7:0] key_code;
    logic key_valid, key_released, key_extended, frame_error;
    typedef struct {logic [7:0] code; logic ext; logic rel; int due;} ev_t;
    ev_t q[$];
    ev_t cur;
    int cyc = 0, tests = 0, fails = 0, err_exp = 0, err_seen = 0;
    logic [7:0] held_code = 8'h00;
    logic held_ext = 1'b0, rst_seen = 1'b1;
    bit m_brk = 1'b0, m_ext = 1'b0;

    always #5 clk = ~clk;

    ps2_keyboard_rx #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk),
        .rst(rst),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_released(key_released),
        .key_extended(key_extended),
        .frame_error(frame_error)
    );

    always @(posedge clk) begin
        cyc++;
        rst_seen <= rst;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // model: one completed frame updates prefix state or predicts a key event
    task automatic model_frame(input logic [7:0] b, input bit ok, input int due);
        if (!ok) begin
            err_exp++;
            m_brk = 1'b0;
            m_ext = 1'b0;
        end else if (b == 8'hF0) m_brk = 1'b1;
        else if (b == 8'hE0) m_ext = 1'b1;
        else begin
            q.push_back('{code: b, ext: m_ext, rel: m_brk, due: due});
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk) ps2_data = bits[i];
            repeat (HB / 2) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10) model_frame(b, !bad_stop && !(bad_par && PAR_EN), cyc + LAT);
            repeat (HB) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (HB / 2) @(negedge clk);
        end
        ps2_data = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        send_bits(b, 1'b0, 1'b0, 11);
    endtask

    always @(negedge clk) begin
        if (rst_seen) begin
            held_code = 8'h00;
            held_ext = 1'b0;
        end
        if (frame_error) err_seen++;
        if (key_valid && key_released) begin
            tests++;
            fails++;
            $display("FAIL both_pulses cyc=%0d", cyc);
        end
        if (q.size() > 0 && cyc > q[0].due) begin
            tests++;
            fails++;
            $display("FAIL missing_pulse code=%0h due=%0d now=%0d", q[0].code, q[0].due, cyc);
            void'(q.pop_front());
        end
        tests++;
        if (key_valid || key_released) begin
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_pulse actual code=%0h rel=%0b required no pulse", key_code, key_released);
            end else begin
                cur = q.pop_front();
                if (cyc != cur.due || key_code !== cur.code || key_extended !== cur.ext || key_released !== cur.rel) begin
                    fails++;
                    $display("FAIL key_event actual cyc=%0d code=%0h ext=%0b rel=%0b required cyc=%0d code=%0h ext=%0b rel=%0b",
                             cyc, key_code, key_extended, key_released, cur.due, cur.code, cur.ext, cur.rel);
                end
                held_code = cur.code;
                held_ext = cur.ext;
            end
        end else if (key_code !== held_code || key_extended !== held_ext) begin
            fails++;
            $display("FAIL hold actual code=%0h ext=%0b required code=%0h ext=%0b", key_code, key_extended, held_code, held_ext);
        end
    end

    initial begin
        logic [7:0] b;
        int r;
        repeat (5) @(negedge clk);
        check("rst_key_code", {24'd0, key_code}, 32'h00);
        check("rst_key_valid", {31'd0, key_valid}, 32'd0);
        check("rst_key_released", {31'd0, key_released}, 32'd0);
        check("rst_key_extended", {31'd0, key_extended}, 32'd0);
        check("rst_frame_error", {31'd0, frame_error}, 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        send(8'h1A);
        check("make_1a_code", {24'd0, key_code}, 32'h1A);
        check("make_1a_ext", {31'd0, key_extended}, 32'd0);
        send(8'hF0);
        send(8'h1A);
        check("break_1a_code", {24'd0, key_code}, 32'h1A);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        check("ext_break_75_code", {24'd0, key_code}, 32'h75);
        check("ext_break_75_ext", {31'd0, key_extended}, 32'd1);
        send(8'h22);
        check("after_ext_22_ext", {31'd0, key_extended}, 32'd0);
        send_bits(8'h22, 1'b1, 1'b0, 11);
        check("bad_parity_errors", err_seen, err_exp);
        check("bad_parity_code", {24'd0, key_code}, 32'h22);
        send(8'hF0);
        send_bits(8'h55, 1'b0, 1'b0, 6);
        repeat (TO + 100) @(negedge clk);
        err_exp++;
        m_brk = 1'b0;
        m_ext = 1'b0;
        check("timeout_error", err_seen, err_exp);
        send(8'h21);
        check("after_timeout_code", {24'd0, key_code}, 32'h21);
        send(8'hF0);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        m_brk = 1'b0;
        m_ext = 1'b0;
        @(negedge clk);
        check("mid_rst_code", {24'd0, key_code}, 32'h00);
        send(8'h1A);
        ps2_data = 1'b0;
        for (int g = 0; g < 4; g++) begin
            @(negedge clk) ps2_clk = 1'b0;
            @(negedge clk) ps2_clk = 1'b1;
            repeat (4) @(negedge clk);
        end
        ps2_data = 1'b1;
        repeat (TO + 20) @(negedge clk);
        check("glitch_no_error", err_seen, err_exp);
        send(8'h1A);
        send(8'h1A);
        for (int n = 0; n < 24; n++) begin
            r = $urandom_range(0, 9);
            b = (r == 0) ? 8'hF0 : (r == 1) ? 8'hE0 : 8'($urandom);
            send_bits(b, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, 11);
        end
        repeat (50) @(negedge clk);
        check("final_queue_empty", q.size(), 32'd0);
        check("final_error_count", err_seen, err_exp);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
